nim_referee: RTL and testbench
==============================

// Module: nim_referee
// PURPOSE
// Game-rule engine for the Nim game. Holds the pile counts and whose turn it is.
// Checks each move a player submits against the rules and applies the legal ones.
// It is the producer side of the scoreboard's score/winner interface: it emits the
// lpScoreUp/rpScoreUp/lpScoreDown/rpScoreDown pulses and the lWinner/rWinner levels.
// Sits between the debounced button/switch front end and the scoreboard.
// PARAMETERS
// NUM_PILES   3   number of piles (max 4; pile index is 2 bits)
// PILE_W      4   bits per pile count
// INIT_PILE0  3   pile 0 count at reset and at newGame
// INIT_PILE1  5   pile 1 count at reset and at newGame
// INIT_PILE2  7   pile 2 count at reset and at newGame
// MAX_TAKE    3   most stones removable in one move
// PORTS
// clk          in   1                 system clock, all state on rising edge
// reset        in   1                 asynchronous, active-high
// newGame      in   1                 1-cycle strobe: restart the game
// move_valid   in   1                 1-cycle strobe: the move_* fields are valid
// move_pile    in   2                 selected pile index
// move_take    in   3                 number of stones to remove
// move_ready   out  1                 1 = a move is accepted this cycle
// turn         out  1                 0 = left player to move, 1 = right player to move
// piles        out  NUM_PILES*PILE_W  pile counts, pile 0 in the LSBs
// illegal      out  1                 1-cycle pulse: rejected move
// lpScoreUp    out  1                 1-cycle pulse: left wins the game
// rpScoreUp    out  1                 1-cycle pulse: right wins the game
// lpScoreDown  out  1                 1-cycle pulse: left illegal-move penalty
// rpScoreDown  out  1                 1-cycle pulse: right illegal-move penalty
// lWinner      out  1                 level: left won; held until newGame/reset
// rWinner      out  1                 level: right won; held until newGame/reset
// BEHAVIOUR
// Reset values
// - Piles = INIT_PILE*; turn = 0; starter = 0; state = PLAY.
// - move_ready = 1; all pulses and winner flags = 0.
// States
// - PLAY:  move_ready = 1.
// - CHECK: one cycle after a legal move; move_ready = 0.
// - AWARD: one cycle; move_ready = 0.
// - DONE:  waits for newGame; move_ready = 0.
// Legality (move strobed in cycle N while in PLAY)
// - Legal iff move_pile < NUM_PILES, 1 <= move_take <= MAX_TAKE,
//   and move_take <= piles[move_pile].
// - Width rule: compare move_take zero-extended to PILE_W; no wrap-around is possible.
// Legal move
// - The selected pile is decremented at the edge ending cycle N and is visible in N+1.
// - State goes to CHECK in N+1.
// CHECK (cycle N+1)
// - If every pile is 0, the mover wins: go to AWARD.
// - Otherwise turn toggles (visible in N+2) and state returns to PLAY (move_ready = 1 in N+2).
// AWARD (cycle N+2)
// - The winner's xWinner flag rises in N+2 and is held.
// - The winner's xpScoreUp is high for exactly cycle N+2.
// - Next state is DONE.
// Illegal move
// - In cycle N+1: illegal = 1 and the mover's xpScoreDown = 1, both for one cycle only.
// - Piles and turn are unchanged; state stays PLAY; the same player moves again.
// Ignored moves
// - move_valid while move_ready = 0 is ignored: no pulse, no state change.
// newGame (any state, highest priority)
// - Piles reload; winner flags clear; pending pulses are suppressed; state goes to PLAY.
// - starter toggles and turn = new starter, visible next cycle. The starting player
//   alternates between games; reset sets starter to left.
// - newGame and move_valid in the same cycle: the move is dropped.
// Reset mid-operation
// - All outputs go to reset values immediately, independent of clk.
// - No pulse may be stretched or replayed after reset deasserts.
// Output registering
// - Every output is registered except move_ready, which is decoded from state.
// STRUCTURE
// Package nim_pkg holds:
// - the state enum {PLAY, CHECK, AWARD, DONE};
// - the player enum {LEFT, RIGHT};
// - the INIT_PILE/MAX_TAKE defaults and the pile-index width.
// One sub-module, nim_move_checker: combinational legality check of
// (piles, move_pile, move_take) -> legal, plus all_empty detection.
// TESTING
// 1. Reset -> piles = 7/5/3 (packed 12'h753), turn = 0, move_ready = 1, all pulses and flags 0.
// 2. Left takes 2 from pile 2 -> piles = 12'h553 at N+1, turn = 1 at N+2, no pulses.
// 3. Right: take = 4, take = 0, pile = 3, then take 3 from pile 0 while it holds 2 ->
//    each gives illegal + rpScoreDown for 1 cycle; piles and turn unchanged.
// 4. Play to all-empty, right makes the last move -> rpScoreUp exactly 1 cycle,
//    rWinner held, move_ready = 0; later move_valid strobes are ignored.
// 5. newGame in DONE -> flags clear, piles = 12'h753, turn = 1. A second newGame gives
//    turn = 0. newGame together with move_valid drops the move.
// 6. Async reset asserted during CHECK, between edges -> outputs at reset values
//    immediately; after release, play resumes with a left move.

Source files
------------

// File: rtl/nim_pkg.sv
// Shared types and default game constants for the Nim referee.
package nim_pkg;
  localparam int NUM_PILES_D = 3;
  localparam int PILE_W_D    = 4;
  localparam int PIDX_W      = 2;
  localparam int TAKE_W      = 3;
  localparam int INIT_PILE0  = 3;
  localparam int INIT_PILE1  = 5;
  localparam int INIT_PILE2  = 7;
  localparam int MAX_TAKE_D  = 3;

  typedef enum logic [1:0] {PLAY, CHECK, AWARD, DONE} state_t;
  typedef enum logic {LEFT = 1'b0, RIGHT = 1'b1} player_t;
endpackage

// File: rtl/nim_referee_if.sv
// Move handshake plus score/winner signalling between front end, referee and scoreboard.
interface nim_referee_if
  import nim_pkg::*;
#(
  parameter int NUM_PILES = NUM_PILES_D,
  parameter int PILE_W    = PILE_W_D
);
  logic                             newGame;
  logic                             move_valid;
  logic [PIDX_W-1:0]                move_pile;
  logic [TAKE_W-1:0]                move_take;
  logic                             move_ready;
  logic                             turn;
  logic [NUM_PILES-1:0][PILE_W-1:0] piles;
  logic                             illegal;
  logic                             lpScoreUp;
  logic                             rpScoreUp;
  logic                             lpScoreDown;
  logic                             rpScoreDown;
  logic                             lWinner;
  logic                             rWinner;

  modport master (
    output newGame, move_valid, move_pile, move_take,
    input  move_ready, turn, piles, illegal, lpScoreUp, rpScoreUp,
           lpScoreDown, rpScoreDown, lWinner, rWinner
  );

  modport slave (
    input  newGame, move_valid, move_pile, move_take,
    output move_ready, turn, piles, illegal, lpScoreUp, rpScoreUp,
           lpScoreDown, rpScoreDown, lWinner, rWinner
  );
endinterface

// File: rtl/nim_move_checker.sv
// Combinational move legality and all-piles-empty detection.
module nim_move_checker
  import nim_pkg::*;
#(
  parameter int NUM_PILES = NUM_PILES_D,
  parameter int PILE_W    = PILE_W_D,
  parameter int MAX_TAKE  = MAX_TAKE_D
) (
  input  logic [NUM_PILES-1:0][PILE_W-1:0] piles,
  input  logic [PIDX_W-1:0]                move_pile,
  input  logic [TAKE_W-1:0]                move_take,
  output logic                             legal,
  output logic                             all_empty
);
  logic [PILE_W-1:0] sel;
  logic              in_range;
  logic [PILE_W-1:0] take_ext;

  assign take_ext = PILE_W'(move_take);

  // Mux rather than direct index so an out-of-range pile never reads past the array.
  always_comb begin
    sel      = '0;
    in_range = 1'b0;
    all_empty = 1'b1;
    for (int i = 0; i < NUM_PILES; i++) begin
      if (move_pile == PIDX_W'(i)) begin
        sel      = piles[i];
        in_range = 1'b1;
      end
      if (piles[i] != '0) all_empty = 1'b0;
    end
  end

  assign legal = in_range && (move_take != '0) &&
                 (move_take <= TAKE_W'(MAX_TAKE)) && (take_ext <= sel);
endmodule

// File: rtl/nim_referee.sv
// Nim rule engine: validates and applies moves, tracks turn, emits score/winner events.
module nim_referee
  import nim_pkg::*;
#(
  parameter int NUM_PILES = NUM_PILES_D,
  parameter int PILE_W    = PILE_W_D,
  parameter int MAX_TAKE  = MAX_TAKE_D
) (
  input  logic          clk,
  input  logic          reset,
  nim_referee_if.slave  io
);
  state_t                           state;
  player_t                          turn_q, starter_q;
  logic [NUM_PILES-1:0][PILE_W-1:0] piles_q, init_piles;
  logic                             legal, all_empty;
  logic                             illegal_q, lup_q, rup_q, ldn_q, rdn_q, lwin_q, rwin_q;

  always_comb begin
    init_piles = '0;
    for (int i = 0; i < NUM_PILES; i++)
      init_piles[i] = (i == 0) ? PILE_W'(INIT_PILE0) :
                      (i == 1) ? PILE_W'(INIT_PILE1) :
                      (i == 2) ? PILE_W'(INIT_PILE2) : '0;
  end

  nim_move_checker #(.NUM_PILES(NUM_PILES), .PILE_W(PILE_W), .MAX_TAKE(MAX_TAKE)) u_chk (
    .piles(piles_q), .move_pile(io.move_pile), .move_take(io.move_take),
    .legal(legal), .all_empty(all_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= PLAY;
      turn_q    <= LEFT;
      starter_q <= LEFT;
      piles_q   <= init_piles;
      illegal_q <= 1'b0;
      lup_q     <= 1'b0;
      rup_q     <= 1'b0;
      ldn_q     <= 1'b0;
      rdn_q     <= 1'b0;
      lwin_q    <= 1'b0;
      rwin_q    <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      lup_q     <= 1'b0;
      rup_q     <= 1'b0;
      ldn_q     <= 1'b0;
      rdn_q     <= 1'b0;
      if (io.newGame) begin
        state     <= PLAY;
        piles_q   <= init_piles;
        lwin_q    <= 1'b0;
        rwin_q    <= 1'b0;
        starter_q <= (starter_q == LEFT) ? RIGHT : LEFT;
        turn_q    <= (starter_q == LEFT) ? RIGHT : LEFT;
      end else begin
        case (state)
          PLAY: if (io.move_valid) begin
            if (legal) begin
              for (int i = 0; i < NUM_PILES; i++)
                if (io.move_pile == PIDX_W'(i))
                  piles_q[i] <= piles_q[i] - PILE_W'(io.move_take);
              state <= CHECK;
            end else begin
              illegal_q <= 1'b1;
              ldn_q     <= (turn_q == LEFT);
              rdn_q     <= (turn_q == RIGHT);
            end
          end
          // The player still holding the turn made the last move.
          CHECK: if (all_empty) begin
            state  <= AWARD;
            lup_q  <= (turn_q == LEFT);
            rup_q  <= (turn_q == RIGHT);
            lwin_q <= (turn_q == LEFT);
            rwin_q <= (turn_q == RIGHT);
          end else begin
            state  <= PLAY;
            turn_q <= (turn_q == LEFT) ? RIGHT : LEFT;
          end
          AWARD:   state <= DONE;
          default: state <= DONE;
        endcase
      end
    end
  end

  assign io.move_ready  = (state == PLAY);
  assign io.turn        = turn_q;
  assign io.piles       = piles_q;
  assign io.illegal     = illegal_q;
  assign io.lpScoreUp   = lup_q;
  assign io.rpScoreUp   = rup_q;
  assign io.lpScoreDown = ldn_q;
  assign io.rpScoreDown = rdn_q;
  assign io.lWinner     = lwin_q;
  assign io.rWinner     = rwin_q;
endmodule

// File: tb/tb_nim_referee.sv
// Directed vector bench for nim_referee: full game, illegal moves, newGame and async reset.
module tb_nim_referee;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  nim_referee_if #(.NUM_PILES(3), .PILE_W(4)) bus ();
  nim_referee dut (.clk(clk), .reset(reset), .io(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  p;
    logic [2:0]  t;
    logic [11:0] piles;
    bit          legal;
    bit          win;
  } vec_t;
  vec_t v[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle_pulses(input string name);
    chk({name, ".illegal"}, bus.illegal, 0);
    chk({name, ".up"}, {bus.lpScoreUp, bus.rpScoreUp}, 0);
    chk({name, ".down"}, {bus.lpScoreDown, bus.rpScoreDown}, 0);
  endtask

  // Strobe a move for one cycle; returns positioned in the following cycle (N+1).
  task automatic move(input logic [1:0] p, input logic [2:0] t, input logic ng);
    @(negedge clk);
    bus.move_valid = 1'b1; bus.move_pile = p; bus.move_take = t; bus.newGame = ng;
    @(negedge clk);
    bus.move_valid = 1'b0; bus.newGame = 1'b0;
  endtask

  task automatic new_game();
    @(negedge clk);
    bus.newGame = 1'b1;
    @(negedge clk);
    bus.newGame = 1'b0;
  endtask

  initial begin
    logic mover;
    v[0]  = '{2'd2, 3'd2, 12'h553, 1'b1, 1'b0};
    v[1]  = '{2'd2, 3'd4, 12'h553, 1'b0, 1'b0};
    v[2]  = '{2'd2, 3'd0, 12'h553, 1'b0, 1'b0};
    v[3]  = '{2'd3, 3'd1, 12'h553, 1'b0, 1'b0};
    v[4]  = '{2'd0, 3'd1, 12'h552, 1'b1, 1'b0};
    v[5]  = '{2'd1, 3'd1, 12'h542, 1'b1, 1'b0};
    v[6]  = '{2'd0, 3'd3, 12'h542, 1'b0, 1'b0};
    v[7]  = '{2'd1, 3'd3, 12'h512, 1'b1, 1'b0};
    v[8]  = '{2'd1, 3'd2, 12'h512, 1'b0, 1'b0};
    v[9]  = '{2'd2, 3'd3, 12'h212, 1'b1, 1'b0};
    v[10] = '{2'd2, 3'd2, 12'h012, 1'b1, 1'b0};
    v[11] = '{2'd0, 3'd2, 12'h010, 1'b1, 1'b0};
    v[12] = '{2'd1, 3'd1, 12'h000, 1'b1, 1'b1};

    reset = 1'b1;
    bus.newGame = 1'b0; bus.move_valid = 1'b0; bus.move_pile = '0; bus.move_take = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst.piles", bus.piles, 12'h753);
    chk("rst.turn", bus.turn, 0);
    chk("rst.ready", bus.move_ready, 1);
    chk("rst.win", {bus.lWinner, bus.rWinner}, 0);
    chk_idle_pulses("rst");

    mover = 1'b0;
    foreach (v[k]) begin
      move(v[k].p, v[k].t, 1'b0);
      chk($sformatf("v%0d.piles", k), bus.piles, v[k].piles);
      chk($sformatf("v%0d.illegal", k), bus.illegal, !v[k].legal);
      chk($sformatf("v%0d.ldown", k), bus.lpScoreDown, !v[k].legal && !mover);
      chk($sformatf("v%0d.rdown", k), bus.rpScoreDown, !v[k].legal && mover);
      chk($sformatf("v%0d.ready1", k), bus.move_ready, !v[k].legal);
      @(negedge clk);
      if (v[k].win) begin
        chk("win.up", {bus.lpScoreUp, bus.rpScoreUp}, {!mover, mover});
        chk("win.flag", {bus.lWinner, bus.rWinner}, {!mover, mover});
        chk("win.ready", bus.move_ready, 0);
        @(negedge clk);
        chk("win.up_once", {bus.lpScoreUp, bus.rpScoreUp}, 0);
        chk("win.held", {bus.lWinner, bus.rWinner}, {!mover, mover});
      end else begin
        if (v[k].legal) mover = !mover;
        chk($sformatf("v%0d.turn", k), bus.turn, mover);
        chk($sformatf("v%0d.ready2", k), bus.move_ready, 1);
        chk_idle_pulses($sformatf("v%0d.n2", k));
      end
    end

    // Moves after the game is over are ignored.
    move(2'd0, 3'd1, 1'b0);
    chk_idle_pulses("done.ign");
    chk("done.piles", bus.piles, 12'h000);
    chk("done.ready", bus.move_ready, 0);
    chk("done.rwin", bus.rWinner, 1);

    new_game();
    chk("ng1.piles", bus.piles, 12'h753);
    chk("ng1.turn", bus.turn, 1);
    chk("ng1.win", {bus.lWinner, bus.rWinner}, 0);
    chk("ng1.ready", bus.move_ready, 1);
    new_game();
    chk("ng2.turn", bus.turn, 0);

    // Move coinciding with newGame is dropped.
    move(2'd0, 3'd1, 1'b1);
    chk("ngmv.piles", bus.piles, 12'h753);
    chk("ngmv.turn", bus.turn, 1);
    chk_idle_pulses("ngmv");
    @(negedge clk);
    chk("ngmv.piles2", bus.piles, 12'h753);
    chk("ngmv.ready", bus.move_ready, 1);

    // Async reset while in CHECK, between clock edges.
    move(2'd0, 3'd1, 1'b0);
    chk("chk.piles", bus.piles, 12'h752);
    chk("chk.ready", bus.move_ready, 0);
    #1 reset = 1'b1;
    #1;
    chk("arst.piles", bus.piles, 12'h753);
    chk("arst.turn", bus.turn, 0);
    chk("arst.ready", bus.move_ready, 1);
    chk("arst.win", {bus.lWinner, bus.rWinner}, 0);
    chk_idle_pulses("arst");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post.turn", bus.turn, 0);
    chk_idle_pulses("post");
    move(2'd2, 3'd1, 1'b0);
    chk("post.piles", bus.piles, 12'h653);
    chk_idle_pulses("post.mv");
    @(negedge clk);
    chk("post.turn2", bus.turn, 1);
    chk("post.ready", bus.move_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
